// File: rtl/dram_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_model_pkg
//  Description : Shared types for the on-chip DRAM user-side responder.
//                Holds the controller state encoding and the width of the
//                read-latency down-counter.
//  Revision    : 1.0  initial release
// ============================================================================
package dram_model_pkg;

   // Controller states; width is explicit so the encoding is fixed.
   typedef enum logic [2:0] {
      ST_CALIB     = 3'd0,
      ST_IDLE      = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_WAIT = 3'd3,
      ST_READ_OUT  = 3'd4
   } dram_state_t;

   // Width of the read-latency down-counter (covers READ_LATENCY up to 256).
   localparam int C_LAT_CNT_W = 8;

endpackage : dram_model_pkg
`default_nettype wire

// File: rtl/dram_model_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dram_model_ram
//  Description : Single-port RAM, 2**ADDR_W words of DATA_W bits, with
//                per-byte write enables and a registered (1-cycle) read.
//                Coded in the single-process byte-write form so that it maps
//                onto block RAM.
//  Ports       : clk_166_67_mhz - clock
//                i_we           - byte write enables (1 = write that byte)
//                i_addr         - word address
//                i_wdata        - write data
//                o_rdata        - read data, one cycle after i_addr
//  Revision    : 1.0  initial release
// ============================================================================
module dram_model_ram #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 12
) (
   input  logic                  clk_166_67_mhz,
   input  logic [DATA_W/8-1:0]   i_we,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [DATA_W-1:0]     i_wdata,
   output logic [DATA_W-1:0]     o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata;

   // Contents are deliberately not reset.
   always_ff @(posedge clk_166_67_mhz) begin
      for (int b = 0; b < DATA_W/8; b++) begin
         if (i_we[b]) begin
            r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule : dram_model_ram
`default_nettype wire

// File: rtl/dram_user_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dram_user_responder
//  Description : Block-RAM backed stand-in for the DDR3 controller wrapper on
//                the DRAM user-side interface. Reproduces calibration delay,
//                busy back-pressure and read latency.
//  Ports       : clk_166_67_mhz        - controller clock
//                dram_rstx_async       - async active-low reset
//                o_rst                 - user reset, async assert / sync release
//                i_ren / i_wen         - read / write request
//                i_addr                - address in 16-bit column units
//                i_data / i_mask       - write data / byte mask (1 = keep byte)
//                i_busy                - user cannot take read data this cycle
//                o_init_calib_complete - model ready
//                o_data / o_data_valid - read data and qualifier
//                o_busy                - command not accepted this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module dram_user_responder
   import dram_model_pkg::*;
#(
   parameter int APP_ADDR_WIDTH = 28,
   parameter int APP_DATA_WIDTH = 128,
   parameter int APP_MASK_WIDTH = 16,
   parameter int MEM_DEPTH_LOG2 = 12,
   parameter int CALIB_CYCLES   = 64,
   parameter int READ_LATENCY   = 4    // must be >= 2 (RAM read takes one cycle)
) (
   input  logic                      clk_166_67_mhz,
   input  logic                      dram_rstx_async,
   output logic                      o_rst,
   input  logic                      i_ren,
   input  logic                      i_wen,
   input  logic [APP_ADDR_WIDTH-2:0] i_addr,
   input  logic [APP_DATA_WIDTH-1:0] i_data,
   input  logic [APP_MASK_WIDTH-1:0] i_mask,
   input  logic                      i_busy,
   output logic                      o_init_calib_complete,
   output logic [APP_DATA_WIDTH-1:0] o_data,
   output logic                      o_data_valid,
   output logic                      o_busy
);

   localparam int C_CAL_W = $clog2(CALIB_CYCLES + 1);

   logic [1:0]                r_rst_sync;
   dram_state_t               r_state;
   dram_state_t               w_state_nxt;
   logic [C_CAL_W-1:0]        r_cal_cnt;
   logic                      r_calib_done;
   logic                      w_cal_last;
   logic [C_LAT_CNT_W-1:0]    r_lat_cnt;
   logic [MEM_DEPTH_LOG2-1:0] r_word_addr;
   logic [APP_DATA_WIDTH-1:0] r_wdata;
   logic [APP_MASK_WIDTH-1:0] r_mask;
   logic [APP_MASK_WIDTH-1:0] w_ram_we;
   logic [APP_DATA_WIDTH-1:0] w_ram_rdata;
   logic                      r_busy;
   logic                      r_valid;
   logic [APP_DATA_WIDTH-1:0] r_data;
   logic                      w_accept;

   // Column bits [2:0] and bits above the RAM depth are intentionally dropped
   // (memory aliases); this keeps the full port visibly consumed.
   logic [APP_ADDR_WIDTH-2:0] w_addr_unused;
   assign w_addr_unused = i_addr;

   // ---------------------------------------------------------------- reset
   // Two-flop synchronizer: asserts with the async reset, releases on the
   // second clock edge after dram_rstx_async rises.
   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) r_rst_sync <= 2'b11;
      else                  r_rst_sync <= {r_rst_sync[0], 1'b0};
   end

   assign o_rst = r_rst_sync[1];

   // ---------------------------------------------------------- calibration
   // Counting starts on the first edge that sees o_rst low, so the last
   // count lands exactly CALIB_CYCLES edges after o_rst falls.
   assign w_cal_last = (r_state == ST_CALIB) && !r_rst_sync[1] &&
                       (r_cal_cnt == C_CAL_W'(CALIB_CYCLES - 1));

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         r_cal_cnt    <= '0;
         r_calib_done <= 1'b0;
      end else begin
         if ((r_state == ST_CALIB) && !r_rst_sync[1]) r_cal_cnt <= r_cal_cnt + 1'b1;
         if (w_cal_last) r_calib_done <= 1'b1;
      end
   end

   // ------------------------------------------------------------------ FSM
   assign w_accept = (r_state == ST_IDLE) && (i_ren || i_wen);

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) r_state <= ST_CALIB;
      else                  r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ram_we    = '0;
      case (r_state)
         ST_CALIB:     if (w_cal_last) w_state_nxt = ST_IDLE;
         // A write wins over a simultaneous read; the read is dropped.
         ST_IDLE: begin
            if (i_wen)      w_state_nxt = ST_WRITE;
            else if (i_ren) w_state_nxt = ST_READ_WAIT;
         end
         ST_WRITE: begin
            w_ram_we    = ~r_mask;
            w_state_nxt = ST_IDLE;
         end
         ST_READ_WAIT: if (r_lat_cnt == '0) w_state_nxt = ST_READ_OUT;
         ST_READ_OUT:  if (!i_busy) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_CALIB;
      endcase
   end

   // ------------------------------------------------------- command capture
   // Address, data and mask are latched at acceptance; the RAM port is
   // driven from these registers in both WRITE and READ_WAIT.
   always_ff @(posedge clk_166_67_mhz) begin
      if (w_accept) begin
         r_word_addr <= i_addr[MEM_DEPTH_LOG2+2:3];
         r_wdata     <= i_data;
         r_mask      <= i_mask;
      end
   end

   // Loaded with READ_LATENCY-1 so READ_OUT is entered on edge
   // acceptance + READ_LATENCY.
   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         r_lat_cnt <= '0;
      end else if (w_accept && !i_wen) begin
         r_lat_cnt <= C_LAT_CNT_W'(READ_LATENCY - 1);
      end else if ((r_state == ST_READ_WAIT) && (r_lat_cnt != '0)) begin
         r_lat_cnt <= r_lat_cnt - 1'b1;
      end
   end

   // ------------------------------------------------------------------ RAM
   dram_model_ram #(
      .DATA_W (APP_DATA_WIDTH),
      .ADDR_W (MEM_DEPTH_LOG2)
   ) u_ram (
      .clk_166_67_mhz (clk_166_67_mhz),
      .i_we           (w_ram_we),
      .i_addr         (r_word_addr),
      .i_wdata        (r_wdata),
      .o_rdata        (w_ram_rdata)
   );

   // -------------------------------------------------------------- outputs
   // Outputs are registered from the next state so they line up with it.
   // Read data is captured once on entry to READ_OUT and held thereafter.
   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         r_busy  <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_valid <= (w_state_nxt == ST_READ_OUT);
         if ((r_state == ST_READ_WAIT) && (w_state_nxt == ST_READ_OUT)) begin
            r_data <= w_ram_rdata;
         end
      end
   end

   assign o_busy                = r_busy;
   assign o_data_valid          = r_valid;
   assign o_data                = r_data;
   assign o_init_calib_complete = r_calib_done;

endmodule : dram_user_responder
`default_nettype wire

// File: tb/tb_dram_user_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_user_responder
//  Description : Directed self-checking bench for dram_user_responder with a
//                reference memory model and an expected-read-data queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dram_user_responder;

   localparam int AW  = 28;
   localparam int DW  = 128;
   localparam int MW  = 16;
   localparam int DL2 = 12;
   localparam int CAL = 64;
   localparam int RL  = 4;

   logic            clk_166_67_mhz = 1'b0;
   logic            dram_rstx_async;
   logic            o_rst;
   logic            i_ren;
   logic            i_wen;
   logic [AW-2:0]   i_addr;
   logic [DW-1:0]   i_data;
   logic [MW-1:0]   i_mask;
   logic            i_busy;
   logic            o_init_calib_complete;
   logic [DW-1:0]   o_data;
   logic            o_data_valid;
   logic            o_busy;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [int];
   logic [DW-1:0] sb_q  [$];

   localparam logic [DW-1:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [DW-1:0] D2 = 128'hA5A5A5A5_01020304_DEADBEEF_CAFEF00D;
   localparam logic [DW-1:0] D3 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

   always #3 clk_166_67_mhz = ~clk_166_67_mhz;

   dram_user_responder #(
      .APP_ADDR_WIDTH (AW),
      .APP_DATA_WIDTH (DW),
      .APP_MASK_WIDTH (MW),
      .MEM_DEPTH_LOG2 (DL2),
      .CALIB_CYCLES   (CAL),
      .READ_LATENCY   (RL)
   ) dut (
      .clk_166_67_mhz        (clk_166_67_mhz),
      .dram_rstx_async       (dram_rstx_async),
      .o_rst                 (o_rst),
      .i_ren                 (i_ren),
      .i_wen                 (i_wen),
      .i_addr                (i_addr),
      .i_data                (i_data),
      .i_mask                (i_mask),
      .i_busy                (i_busy),
      .o_init_calib_complete (o_init_calib_complete),
      .o_data                (o_data),
      .o_data_valid          (o_data_valid),
      .o_busy                (o_busy)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_166_67_mhz);
      #1;
   endtask

   function automatic int widx(input logic [AW-2:0] a);
      return int'((a >> 3) & ((1 << DL2) - 1));
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wr,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = wr[b*8 +: 8];
      return r;
   endfunction

   task automatic model_write(input logic [AW-2:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      int k;
      logic [DW-1:0] old;
      k   = widx(a);
      old = model.exists(k) ? model[k] : '0;
      model[k] = merge(old, d, m);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (o_busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check("ready_timeout", o_busy, 1'b0);
   endtask

   task automatic do_write(input logic [AW-2:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      wait_ready();
      i_wen = 1'b1; i_addr = a; i_data = d; i_mask = m;
      model_write(a, d, m);
      tick();
      i_wen = 1'b0;
      check("wr_busy", o_busy, 1'b1);
      tick();
      check("wr_done_busy", o_busy, 1'b0);
   endtask

   task automatic do_read(input logic [AW-2:0] a, input int hold, input string tag);
      logic [DW-1:0] exp;
      wait_ready();
      i_ren  = 1'b1;
      i_addr = a;
      i_busy = (hold > 0);
      sb_q.push_back(model[widx(a)]);
      tick();
      i_ren = 1'b0;
      check({tag, "_busy_acc"}, o_busy, 1'b1);
      for (int k = 1; k < RL; k++) begin
         tick();
         check({tag, "_early_valid"}, o_data_valid, 1'b0);
      end
      tick();
      check({tag, "_valid"}, o_data_valid, 1'b1);
      check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1'b1);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
      check({tag, "_data"}, o_data, exp);
      for (int h = 0; h < hold; h++) begin
         i_ren = (h == 1);
         tick();
         check({tag, "_hold_valid"}, o_data_valid, 1'b1);
         check({tag, "_hold_data"}, o_data, exp);
         check({tag, "_hold_busy"}, o_busy, 1'b1);
      end
      i_ren  = 1'b0;
      i_busy = 1'b0;
      tick();
      check({tag, "_valid_drop"}, o_data_valid, 1'b0);
      check({tag, "_busy_drop"}, o_busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen_valid;
      int n;

      dram_rstx_async = 1'b1;
      i_ren = 1'b0; i_wen = 1'b0; i_addr = '0; i_data = '0; i_mask = '0; i_busy = 1'b0;
      #1 dram_rstx_async = 1'b0;
      tick(); tick(); tick();

      // Reset values.
      check("rst_o_rst", o_rst, 1'b1);
      check("rst_calib", o_init_calib_complete, 1'b0);
      check("rst_busy", o_busy, 1'b1);
      check("rst_valid", o_data_valid, 1'b0);
      check("rst_data", o_data, '0);

      // Reset release and calibration timing.
      dram_rstx_async = 1'b1;
      tick();
      check("rst_sync_edge1", o_rst, 1'b1);
      tick();
      check("rst_sync_edge2", o_rst, 1'b0);
      for (int k = 1; k <= CAL; k++) begin
         tick();
         if (k < CAL) begin
            check("calib_early", o_init_calib_complete, 1'b0);
            check("calib_busy", o_busy, 1'b1);
         end else begin
            check("calib_rise", o_init_calib_complete, 1'b1);
            check("calib_busy_fall", o_busy, 1'b0);
         end
      end

      // Full write then read back.
      do_write(27'h10, D1, 16'h0000);
      do_read(27'h10, 0, "full_rd");

      // Masked writes: seed byte 0, then overwrite only byte 0 with FF.
      do_write(27'h10, 128'h5A, 16'hFFFE);
      do_read(27'h10, 0, "seed_rd");
      do_write(27'h10, {DW{1'b1}}, 16'hFFFE);
      do_read(27'h10, 0, "mask_b0_rd");
      do_write(27'h10, {DW{1'b1}}, 16'h7FFF);
      do_read(27'h10, 0, "mask_b15_rd");

      // Back-pressure: held for 5 busy cycles, ren pulse in the hold dropped.
      do_read(27'h10, 5, "bp_rd");
      for (int k = 0; k < RL + 2; k++) begin
         tick();
         check("bp_no_extra_valid", o_data_valid, 1'b0);
      end

      // Aliasing: 0x8008 and 0x0008 map to the same word.
      do_write(27'h8008, D2, 16'h0000);
      do_read(27'h0008, 0, "alias_rd");

      // Simultaneous read and write: only the write happens.
      wait_ready();
      i_ren = 1'b1; i_wen = 1'b1; i_addr = 27'h20; i_data = D3; i_mask = 16'h0000;
      model_write(27'h20, D3, 16'h0000);
      tick();
      i_ren = 1'b0; i_wen = 1'b0;
      check("simul_busy", o_busy, 1'b1);
      for (int k = 0; k < RL + 3; k++) begin
         tick();
         check("simul_no_valid", o_data_valid, 1'b0);
      end
      do_read(27'h20, 0, "simul_rd");

      // Reset two cycles into a read: the read is abandoned, RAM survives.
      wait_ready();
      i_ren = 1'b1; i_addr = 27'h10;
      tick();
      i_ren = 1'b0;
      tick(); tick();
      dram_rstx_async = 1'b0;
      #1;
      check("midrd_rst", o_rst, 1'b1);
      check("midrd_busy", o_busy, 1'b1);
      check("midrd_valid", o_data_valid, 1'b0);
      check("midrd_calib", o_init_calib_complete, 1'b0);
      tick(); tick();
      dram_rstx_async = 1'b1;
      seen_valid = 1'b0;
      n = 0;
      while (o_init_calib_complete !== 1'b1 && n < 300) begin
         tick();
         if (o_data_valid !== 1'b0) seen_valid = 1'b1;
         n++;
      end
      check("midrd_recal", o_init_calib_complete, 1'b1);
      check("midrd_never_valid", seen_valid, 1'b0);
      do_read(27'h10, 0, "after_rst_rd");
      do_read(27'h20, 0, "after_rst_rd2");

      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dram_user_responder
`default_nettype wire

// File: doc/dram_user_responder.md
# dram_user_responder

Synthesizable responder for the DRAM user-side interface (`ren`/`wen`/`addr`/`data`/`mask`/`busy`/`valid`/`calib`). It answers the same command set as the DDR3 controller wrapper, backed by on-chip block RAM. It replaces the DDR3 path on boards without DDR3 and in fast simulation, and it sits directly on the core's DRAM port. It runs in the 166.67 MHz controller clock domain and reproduces calibration delay, busy back-pressure and read latency.

## Interface
- `APP_ADDR_WIDTH`, default 28: controller address width; the port uses `APP_ADDR_WIDTH-1` bits.
- `APP_DATA_WIDTH`, default 128: width of one burst beat group.
- `APP_MASK_WIDTH`, default 16: byte mask width, `APP_DATA_WIDTH/8`.
- `MEM_DEPTH_LOG2`, default 12: log2 of the number of 128-bit words held.
- `CALIB_CYCLES`, default 64: cycles from reset release to `o_init_calib_complete`.
- `READ_LATENCY`, default 4: cycles from read acceptance to first `o_data_valid`; must be ≥ 2.

Ports:
- `clk_166_67_mhz`, in, 1: clock.
- `dram_rstx_async`, in, 1: reset, asynchronous, active-low.
- `o_rst`, out, 1: active-high user reset. Asserts asynchronously; deasserts synchronously through 2 flops.
- `i_ren`, in, 1: read request.
- `i_wen`, in, 1: write request.
- `i_addr`, in, `APP_ADDR_WIDTH-1`: address in 16-bit column units.
- `i_data`, in, `APP_DATA_WIDTH`: write data.
- `i_mask`, in, `APP_MASK_WIDTH`: byte mask; 1 = byte NOT written.
- `i_busy`, in, 1: user cannot take read data this cycle.
- `o_init_calib_complete`, out, 1: model ready.
- `o_data`, out, `APP_DATA_WIDTH`: read data.
- `o_data_valid`, out, 1: `o_data` valid.
- `o_busy`, out, 1: new command not accepted.

## Operation
- **Reset values:** `o_rst`=1, `o_init_calib_complete`=0, `o_busy`=1, `o_data_valid`=0, `o_data`=0. RAM contents are not reset.
- **Word index:** `i_addr[MEM_DEPTH_LOG2+2:3]`. `i_addr[2:0]` is ignored. Higher bits are ignored, so the memory aliases (wraps).
- **Command acceptance:** a command is accepted on an edge where (`i_ren`|`i_wen`) && !`o_busy`. Requests presented while busy are dropped, not queued.
- **Simultaneous `i_ren` and `i_wen`:** the write is performed and the read is discarded.
- **FSM states:**
  - CALIB: counts `CALIB_CYCLES` after `o_rst` falls, then goes to IDLE.
  - IDLE: `o_busy`=0.
  - WRITE: one cycle. Byte-enabled write with enable = ~`i_mask`, using data captured at acceptance. Then goes to IDLE.
  - READ_WAIT: a latency counter counts down; then goes to READ_OUT.
  - READ_OUT: `o_data_valid`=1. Leaves for IDLE on the first cycle where `i_busy`=0, which is the consumption cycle. Data and valid hold unchanged while `i_busy`=1.
- `o_busy`=1 in every state except IDLE.
- **Asynchronous reset mid-operation:** the FSM returns to CALIB, any in-flight read is abandoned, and a write not yet committed is lost.

## Timing
- Write accepted at edge T: RAM is updated at edge T+1, and `o_busy` is 1 during cycle T→T+1. The next command is accepted at T+2 at the earliest.
- Read accepted at edge T: `o_data_valid` rises after edge T+`READ_LATENCY`. `o_busy` falls in the cycle after consumption.
- **Read-after-write:** a read accepted after a write's commit edge returns the new data; no hazard is possible.
- **Calibration:** `o_init_calib_complete` rises exactly `CALIB_CYCLES` edges after `o_rst` deasserts and stays high until reset.
- All outputs are registered.

## Structure
- Package `dram_model_pkg`: the state enum (CALIB, IDLE, WRITE, READ_WAIT, READ_OUT) and a latency-counter width localparam.
- Sub-module `dram_model_ram`: single-port RAM of `2**MEM_DEPTH_LOG2` × `APP_DATA_WIDTH`.
  - Byte write enables.
  - Registered read with 1-cycle latency.
  - Inferable as BRAM.
- Top level contains: reset synchronizer, calibration counter, FSM, latency counter, output hold registers.

## Test plan
- **Reset and calibration:** deassert reset, default parameters → `o_rst` falls 2 edges later; `o_init_calib_complete` rises 64 edges after that; `o_busy` is 1 throughout and falls with calib.
- **Full write then read:** write addr 0x10 with data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0x0000; then read addr 0x10 → same data; valid rises 4 cycles after acceptance and lasts 1 cycle with `i_busy`=0.
- **Masked write:** write addr 0x10 with all-ones data and mask 0xFFFE; read back → byte 0 = 0xFF, remaining bytes unchanged (0x00112233_44556677_8899AABB_CCDDEE**FF**, low byte already FF, so seed a different byte value first).
- **Back-pressure:** read with `i_busy`=1 for 5 cycles at valid time → `o_data_valid` and `o_data` held stable 6 cycles; `o_busy` stays 1; `i_ren` pulses during the hold are ignored.
- **Aliasing and simultaneous request:** write addr 0x8008 with `MEM_DEPTH_LOG2`=12 → read addr 0x0008 returns it. `i_ren` and `i_wen` together → write committed, no `o_data_valid`.
- **Reset mid-read:** assert reset 2 cycles after read acceptance → `o_data_valid` never asserts; after re-calibration, RAM still holds the previously written data.
